// File: rtl/escalonador_pkg.sv
// Shared types and widths for the round-robin process scheduler.
package escalonador_pkg;

  localparam int unsigned PID_W   = 5;
  localparam int unsigned QUANT_W = 16;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    StOcioso = 2'd0,
    StExec   = 2'd1,
    StPedido = 2'd2,
    StTroca  = 2'd3
  } estado_e;

endpackage

// File: rtl/escalonador_processos_if.sv
// Scheduler <-> processor/OS signal bundle; direction prefixes are from the scheduler's view.
interface escalonador_processos_if;
  import escalonador_pkg::*;

  logic               i_enable;
  logic               i_criar;
  logic [PID_W-1:0]   i_criar_pid;
  logic               i_matar;
  logic [PID_W-1:0]   i_matar_pid;
  logic               i_yield;
  logic               i_switch_ack;
  logic               o_switch_req;
  logic [PID_W-1:0]   o_next_pid;
  logic [PID_W-1:0]   o_pid_atual;
  logic [ADDR_W-1:0]  o_deslocamento_memoria;
  logic [QUANT_W-1:0] o_quantum_restante;
  logic               o_ocioso;

  modport slave (
    input  i_enable, i_criar, i_criar_pid, i_matar, i_matar_pid, i_yield, i_switch_ack,
    output o_switch_req, o_next_pid, o_pid_atual, o_deslocamento_memoria,
           o_quantum_restante, o_ocioso
  );

  modport master (
    output i_enable, i_criar, i_criar_pid, i_matar, i_matar_pid, i_yield, i_switch_ack,
    input  o_switch_req, o_next_pid, o_pid_atual, o_deslocamento_memoria,
           o_quantum_restante, o_ocioso
  );

endinterface

// File: rtl/busca_round_robin.sv
// Rotating-priority search: first ready PID after i_pid_atual, wrapping, ending on itself.
module busca_round_robin
  import escalonador_pkg::*;
#(
  parameter int unsigned NUM_PROC = 8
) (
  input  logic [NUM_PROC-1:0] i_ready,
  input  logic [PID_W-1:0]    i_pid_atual,
  output logic [PID_W-1:0]    o_next_pid,
  output logic                o_found
);

  logic [NUM_PROC-1:0] w_sh;

  always_comb begin
    o_found    = 1'b0;
    o_next_pid = '0;
    w_sh       = '0;
    for (int unsigned k = 1; k <= NUM_PROC; k++) begin
      w_sh = i_ready >> ((32'(i_pid_atual) + k) % NUM_PROC);
      if (!o_found && w_sh[0]) begin
        o_found    = 1'b1;
        o_next_pid = PID_W'((32'(i_pid_atual) + k) % NUM_PROC);
      end
    end
  end

endmodule

// File: rtl/escalonador_processos.sv
// Round-robin preemptive scheduler: ready table, quantum timer and context-switch handshake.
module escalonador_processos
  import escalonador_pkg::*;
#(
  parameter int unsigned NUM_PROC  = 8,
  parameter int unsigned QUANTUM   = 64,
  parameter int unsigned PAGE_LOG2 = 10
) (
  input logic                      i_clock,
  input logic                      i_reset,
  escalonador_processos_if.slave   io_bus
);

  localparam logic [QUANT_W-1:0]  QuantumVal = QUANT_W'(QUANTUM);
  localparam logic [NUM_PROC-1:0] UmBit      = NUM_PROC'(1);

  if (NUM_PROC < 1 || NUM_PROC > 32) begin : g_num_proc_chk
    $error("NUM_PROC out of range");
  end
  if (QUANTUM < 1 || QUANTUM > 65535) begin : g_quantum_chk
    $error("QUANTUM out of range");
  end

  estado_e             r_state, w_state_nxt;
  logic [NUM_PROC-1:0] r_ready, w_ready_nxt;
  logic [NUM_PROC-1:0] w_criar_mask, w_matar_mask;
  logic [NUM_PROC-1:0] w_sh_atual, w_sh_next;
  logic [PID_W-1:0]    r_pid_atual, w_pid_nxt;
  logic [PID_W-1:0]    r_next_pid, w_next_nxt;
  logic [PID_W-1:0]    w_busca_pid;
  logic                w_busca_ok;
  logic [ADDR_W-1:0]   r_desloc, w_desloc_nxt;
  logic [QUANT_W-1:0]  r_quant, w_quant_nxt;
  logic                w_ready_atual, w_ready_next;
  logic                w_expira, w_evento;

  busca_round_robin #(
    .NUM_PROC (NUM_PROC)
  ) u_busca (
    .i_ready     (r_ready),
    .i_pid_atual (r_pid_atual),
    .o_next_pid  (w_busca_pid),
    .o_found     (w_busca_ok)
  );

  // Kill is applied after create so a same-cycle create/kill leaves the bit clear.
  always_comb begin
    w_criar_mask = '0;
    w_matar_mask = '0;
    if (io_bus.i_criar && (32'(io_bus.i_criar_pid) < NUM_PROC)) begin
      w_criar_mask = UmBit << io_bus.i_criar_pid;
    end
    if (io_bus.i_matar && (32'(io_bus.i_matar_pid) < NUM_PROC)) begin
      w_matar_mask = UmBit << io_bus.i_matar_pid;
    end
    w_ready_nxt = (r_ready | w_criar_mask) & ~w_matar_mask;
  end

  assign w_sh_atual    = r_ready >> r_pid_atual;
  assign w_sh_next     = r_ready >> r_next_pid;
  assign w_ready_atual = w_sh_atual[0];
  assign w_ready_next  = w_sh_next[0];
  assign w_expira      = io_bus.i_enable && (r_quant == QUANT_W'(1));
  assign w_evento      = w_expira || io_bus.i_yield || !w_ready_atual;

  always_comb begin
    w_state_nxt  = r_state;
    w_pid_nxt    = r_pid_atual;
    w_next_nxt   = r_next_pid;
    w_desloc_nxt = r_desloc;
    w_quant_nxt  = r_quant;
    unique case (r_state)
      StOcioso: begin
        if (w_busca_ok) begin
          w_state_nxt = StPedido;
          w_next_nxt  = w_busca_pid;
        end
      end
      StExec: begin
        if (io_bus.i_enable) begin
          w_quant_nxt = r_quant - QUANT_W'(1);
        end
        if (w_evento) begin
          if (!w_busca_ok) begin
            w_state_nxt = StOcioso;
            w_quant_nxt = '0;
          end else if (w_busca_pid != r_pid_atual) begin
            w_state_nxt = StPedido;
            w_next_nxt  = w_busca_pid;
          end else begin
            // Sole ready process keeps the CPU with a fresh slice, no handshake.
            w_quant_nxt = QuantumVal;
          end
        end
      end
      StPedido: begin
        // A vanished candidate takes priority over a same-cycle ack.
        if (!w_ready_next) begin
          if (!w_busca_ok) begin
            w_state_nxt = StOcioso;
            w_quant_nxt = '0;
          end else begin
            w_next_nxt = w_busca_pid;
          end
        end else if (io_bus.i_switch_ack) begin
          w_state_nxt  = StTroca;
          w_pid_nxt    = r_next_pid;
          w_desloc_nxt = ADDR_W'(r_next_pid) << PAGE_LOG2;
          w_quant_nxt  = QuantumVal;
        end
      end
      StTroca: begin
        w_state_nxt = StExec;
      end
      default: begin
        w_state_nxt = StOcioso;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= StOcioso;
      r_ready     <= '0;
      r_pid_atual <= '0;
      r_next_pid  <= '0;
      r_desloc    <= '0;
      r_quant     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_pid_atual <= w_pid_nxt;
      r_next_pid  <= w_next_nxt;
      r_desloc    <= w_desloc_nxt;
      r_quant     <= w_quant_nxt;
    end
  end

  assign io_bus.o_switch_req           = (r_state == StPedido);
  assign io_bus.o_ocioso               = (r_state == StOcioso);
  assign io_bus.o_next_pid             = r_next_pid;
  assign io_bus.o_pid_atual            = r_pid_atual;
  assign io_bus.o_deslocamento_memoria = r_desloc;
  assign io_bus.o_quantum_restante     = r_quant;

  a_pid_range : assert property (@(posedge i_clock) 32'(r_pid_atual) < NUM_PROC);
  a_next_range : assert property (@(posedge i_clock) 32'(r_next_pid) < NUM_PROC);

endmodule

// File: tb/tb_escalonador_processos.sv
// Self-checking bench: directed scenarios plus randomized traffic against a PID-level model.
module tb_escalonador_processos;

  localparam int NP = 8;
  localparam int QT = 64;
  localparam int PL = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  escalonador_processos_if bus ();

  escalonador_processos #(
    .NUM_PROC  (NP),
    .QUANTUM   (QT),
    .PAGE_LOG2 (PL)
  ) u_dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who runs, who is waiting to run, slice left.
  typedef enum {MIdle, MRun, MWait, MLoad} mmode_e;
  mmode_e m_mode;
  bit     m_ready[NP];
  int     m_pid, m_next, m_q;

  function automatic int m_search();
    for (int off = 1; off <= NP; off++) begin
      if (m_ready[(m_pid + off) % NP]) return (m_pid + off) % NP;
    end
    return -1;
  endfunction

  task automatic m_step();
    bit nr[NP];
    int s;
    bit ev;
    nr = m_ready;
    if (bus.i_criar && int'(bus.i_criar_pid) < NP) nr[int'(bus.i_criar_pid)] = 1'b1;
    if (bus.i_matar && int'(bus.i_matar_pid) < NP) nr[int'(bus.i_matar_pid)] = 1'b0;
    if (!rst_n) begin
      m_mode = MIdle;
      m_pid  = 0;
      m_next = 0;
      m_q    = 0;
      foreach (m_ready[i]) m_ready[i] = 1'b0;
      return;
    end
    s = m_search();
    case (m_mode)
      MIdle: if (s >= 0) begin m_mode = MWait; m_next = s; end
      MRun: begin
        ev = (bus.i_enable && m_q == 1) || bus.i_yield || !m_ready[m_pid];
        if (bus.i_enable) m_q = m_q - 1;
        if (ev) begin
          if (s < 0) begin m_mode = MIdle; m_q = 0; end
          else if (s != m_pid) begin m_mode = MWait; m_next = s; end
          else m_q = QT;
        end
      end
      MWait: begin
        if (!m_ready[m_next]) begin
          if (s < 0) begin m_mode = MIdle; m_q = 0; end
          else m_next = s;
        end else if (bus.i_switch_ack) begin
          m_mode = MLoad;
          m_pid  = m_next;
          m_q    = QT;
        end
      end
      MLoad: m_mode = MRun;
      default: m_mode = MIdle;
    endcase
    m_ready = nr;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle_in();
    bus.i_criar      = 1'b0;
    bus.i_criar_pid  = '0;
    bus.i_matar      = 1'b0;
    bus.i_matar_pid  = '0;
    bus.i_yield      = 1'b0;
    bus.i_switch_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
    bus.i_enable = 1'b1;
  endtask

  task automatic criar(input int pid);
    bus.i_criar = 1'b1; bus.i_criar_pid = 5'(pid);
    tick();
    idle_in();
  endtask

  task automatic matar(input int pid);
    bus.i_matar = 1'b1; bus.i_matar_pid = 5'(pid);
    tick();
    idle_in();
  endtask

  task automatic ack();
    bus.i_switch_ack = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic run_until_req(input int max, output int n);
    n = 0;
    while (!bus.o_switch_req && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    idle_in();
    bus.i_enable = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (bus.o_switch_req !== 1'b0 || bus.o_next_pid !== 5'd0 || bus.o_pid_atual !== 5'd0 ||
        bus.o_deslocamento_memoria !== 32'd0 || bus.o_quantum_restante !== 16'd0 ||
        bus.o_ocioso !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: req=%0b next=%0d pid=%0d desl=%h q=%0d ocioso=%0b, want 0 0 0 0 0 1",
               bus.o_switch_req, bus.o_next_pid, bus.o_pid_atual, bus.o_deslocamento_memoria,
               bus.o_quantum_restante, bus.o_ocioso);
    end
    rst_n = 1'b1;
    bus.i_enable = 1'b1;
  endtask

  task automatic test_criar_switch();
    do_reset();
    criar(3);
    tick();
    n_total++;
    if (bus.o_switch_req !== 1'b1 || bus.o_next_pid !== 5'd3 || bus.o_ocioso !== 1'b0) begin
      n_bad++;
      $display("FAIL criar_req: req=%0b next=%0d ocioso=%0b, want 1 3 0",
               bus.o_switch_req, bus.o_next_pid, bus.o_ocioso);
    end
    ack();
    n_total++;
    if (bus.o_pid_atual !== 5'd3 || bus.o_deslocamento_memoria !== 32'h0000_0C00 ||
        bus.o_quantum_restante !== 16'd64 || bus.o_switch_req !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_load: pid=%0d desl=%h q=%0d req=%0b, want 3 00000c00 64 0",
               bus.o_pid_atual, bus.o_deslocamento_memoria, bus.o_quantum_restante,
               bus.o_switch_req);
    end
    tick();
    tick();
    n_total++;
    if (bus.o_quantum_restante !== 16'd63) begin
      n_bad++;
      $display("FAIL first_decrement: q=%0d want 63", bus.o_quantum_restante);
    end
  endtask

  task automatic test_rotation();
    int n;
    do_reset();
    criar(2);
    criar(1);
    criar(5);
    ack();
    tick();
    n_total++;
    if (bus.o_pid_atual !== 5'd2) begin
      n_bad++;
      $display("FAIL rot_start: pid=%0d want 2", bus.o_pid_atual);
    end
    run_until_req(200, n);
    n_total++;
    if (n !== QT || bus.o_next_pid !== 5'd5) begin
      n_bad++;
      $display("FAIL rot_expiry: cycles=%0d next=%0d, want %0d 5", n, bus.o_next_pid, QT);
    end
    ack();
    tick();
    run_until_req(200, n);
    n_total++;
    if (n !== QT || bus.o_next_pid !== 5'd1 || bus.o_pid_atual !== 5'd5) begin
      n_bad++;
      $display("FAIL rot_wrap: cycles=%0d next=%0d pid=%0d, want %0d 1 5",
               n, bus.o_next_pid, bus.o_pid_atual, QT);
    end
  endtask

  task automatic test_single_reload();
    do_reset();
    criar(4);
    tick();
    ack();
    tick();
    repeat (QT - 1) tick();
    n_total++;
    if (bus.o_quantum_restante !== 16'd1 || bus.o_switch_req !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pre: q=%0d req=%0b, want 1 0", bus.o_quantum_restante,
               bus.o_switch_req);
    end
    tick();
    n_total++;
    if (bus.o_quantum_restante !== 16'd64 || bus.o_switch_req !== 1'b0 ||
        bus.o_pid_atual !== 5'd4) begin
      n_bad++;
      $display("FAIL single_reload: q=%0d req=%0b pid=%0d, want 64 0 4",
               bus.o_quantum_restante, bus.o_switch_req, bus.o_pid_atual);
    end
  endtask

  task automatic test_freeze();
    // continues from test_single_reload: PID 4 running with a full slice
    bus.i_enable = 1'b0;
    repeat (5) tick();
    n_total++;
    if (bus.o_quantum_restante !== 16'd64) begin
      n_bad++;
      $display("FAIL enable_freeze: q=%0d want 64", bus.o_quantum_restante);
    end
    bus.i_enable = 1'b1;
  endtask

  task automatic test_yield_kill();
    do_reset();
    criar(1);
    criar(6);
    ack();
    tick();
    tick();
    bus.i_yield = 1'b1;
    tick();
    idle_in();
    n_total++;
    if (bus.o_switch_req !== 1'b1 || bus.o_next_pid !== 5'd6) begin
      n_bad++;
      $display("FAIL yield_req: req=%0b next=%0d, want 1 6", bus.o_switch_req, bus.o_next_pid);
    end
    criar(7);
    matar(6);
    tick();
    n_total++;
    if (bus.o_switch_req !== 1'b1 || bus.o_next_pid !== 5'd7) begin
      n_bad++;
      $display("FAIL kill_retarget: req=%0b next=%0d, want 1 7", bus.o_switch_req,
               bus.o_next_pid);
    end
    matar(1);
    matar(7);
    tick();
    n_total++;
    if (bus.o_switch_req !== 1'b0 || bus.o_ocioso !== 1'b1) begin
      n_bad++;
      $display("FAIL kill_all: req=%0b ocioso=%0b, want 0 1", bus.o_switch_req, bus.o_ocioso);
    end
  endtask

  task automatic test_yield_expiry();
    do_reset();
    criar(1);
    criar(6);
    ack();
    tick();
    repeat (QT - 1) tick();
    bus.i_yield = 1'b1;
    tick();
    idle_in();
    n_total++;
    if (bus.o_switch_req !== 1'b1 || bus.o_next_pid !== 5'd6 || bus.o_pid_atual !== 5'd1) begin
      n_bad++;
      $display("FAIL yield_expiry_req: req=%0b next=%0d pid=%0d, want 1 6 1",
               bus.o_switch_req, bus.o_next_pid, bus.o_pid_atual);
    end
    ack();
    tick();
    tick();
    n_total++;
    if (bus.o_switch_req !== 1'b0 || bus.o_pid_atual !== 5'd6 ||
        bus.o_quantum_restante !== 16'd63) begin
      n_bad++;
      $display("FAIL yield_expiry_once: req=%0b pid=%0d q=%0d, want 0 6 63",
               bus.o_switch_req, bus.o_pid_atual, bus.o_quantum_restante);
    end
  endtask

  task automatic test_table_edges();
    do_reset();
    bus.i_criar = 1'b1; bus.i_criar_pid = 5'd2;
    bus.i_matar = 1'b1; bus.i_matar_pid = 5'd2;
    tick();
    idle_in();
    tick();
    tick();
    n_total++;
    if (bus.o_ocioso !== 1'b1 || bus.o_switch_req !== 1'b0) begin
      n_bad++;
      $display("FAIL criar_matar_same: ocioso=%0b req=%0b, want 1 0", bus.o_ocioso,
               bus.o_switch_req);
    end
    criar(9);
    tick();
    tick();
    n_total++;
    if (bus.o_ocioso !== 1'b1 || bus.o_switch_req !== 1'b0) begin
      n_bad++;
      $display("FAIL criar_out_of_range: ocioso=%0b req=%0b, want 1 0", bus.o_ocioso,
               bus.o_switch_req);
    end
  endtask

  task automatic test_reset_pedido();
    do_reset();
    criar(5);
    tick();
    n_total++;
    if (bus.o_switch_req !== 1'b1 || bus.o_next_pid !== 5'd5) begin
      n_bad++;
      $display("FAIL pedido_entry: req=%0b next=%0d, want 1 5", bus.o_switch_req,
               bus.o_next_pid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if (bus.o_switch_req !== 1'b0 || bus.o_next_pid !== 5'd0 || bus.o_pid_atual !== 5'd0 ||
        bus.o_deslocamento_memoria !== 32'd0 || bus.o_quantum_restante !== 16'd0 ||
        bus.o_ocioso !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_pedido: req=%0b next=%0d pid=%0d desl=%h q=%0d ocioso=%0b",
               bus.o_switch_req, bus.o_next_pid, bus.o_pid_atual, bus.o_deslocamento_memoria,
               bus.o_quantum_restante, bus.o_ocioso);
    end
    tick();
    tick();
    n_total++;
    if (bus.o_ocioso !== 1'b1 || bus.o_switch_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_clears_table: ocioso=%0b req=%0b, want 1 0", bus.o_ocioso,
               bus.o_switch_req);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.i_criar      = ($urandom_range(0, 99) < 30);
      bus.i_criar_pid  = 5'($urandom_range(0, 9));
      bus.i_matar      = ($urandom_range(0, 99) < 12);
      bus.i_matar_pid  = 5'($urandom_range(0, 9));
      bus.i_yield      = ($urandom_range(0, 99) < 8);
      bus.i_switch_ack = ($urandom_range(0, 99) < 35);
      bus.i_enable     = ($urandom_range(0, 99) < 85);
      rst_n            = ($urandom_range(0, 999) >= 3);
      tick();
      n_total++;
      if (bus.o_switch_req !== (m_mode == MWait) || bus.o_ocioso !== (m_mode == MIdle) ||
          bus.o_next_pid !== 5'(m_next) || bus.o_pid_atual !== 5'(m_pid) ||
          bus.o_deslocamento_memoria !== (32'(m_pid) << PL) ||
          bus.o_quantum_restante !== 16'(m_q)) begin
        n_bad++;
        $display("FAIL random_c%0d: req=%0b ocioso=%0b next=%0d pid=%0d desl=%h q=%0d; model req=%0b ocioso=%0b next=%0d pid=%0d q=%0d",
                 c, bus.o_switch_req, bus.o_ocioso, bus.o_next_pid, bus.o_pid_atual,
                 bus.o_deslocamento_memoria, bus.o_quantum_restante, m_mode == MWait,
                 m_mode == MIdle, m_next, m_pid, m_q);
      end
    end
    rst_n = 1'b1;
    idle_in();
  endtask

  initial begin
    idle_in();
    bus.i_enable = 1'b0;
    test_reset();
    test_criar_switch();
    test_rotation();
    test_single_reload();
    test_freeze();
    test_yield_kill();
    test_yield_expiry();
    test_table_edges();
    test_reset_pedido();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/escalonador_processos.md
Name: escalonador_processos

Overview:
- Round-robin preemptive process scheduler that sequences the single-cycle processor between user processes.
- Keeps a ready table indexed by PID and runs a quantum timer.
- Raises a context-switch request to the processor/OS, hands over the next PID, and drives the per-process memory displacement that the processor adds to data addresses (DeslocamentoMemoria input).
- Sits beside the processor; the OS acknowledges the switch after saving context.

Parameters:
- NUM_PROC, 8, number of schedulable PIDs (0..NUM_PROC-1), max 32.
- QUANTUM, 64, clock cycles (while Enable=1) per time slice, 1..65535.
- PAGE_LOG2, 10, log2 of the memory region size per process; displacement = PID << PAGE_LOG2.

Ports:
- Clock, input, 1: system clock, all logic on posedge.
- Reset, input, 1: synchronous, active-low reset.
- Enable, input, 1: scheduler active; the quantum counter only decrements when 1.
- Criar, input, 1: mark process CriarPID ready.
- CriarPID, input, 5: PID to create.
- Matar, input, 1: remove process MatarPID from the ready table.
- MatarPID, input, 5: PID to remove.
- Yield, input, 1: voluntary release by the running process (syscall); single-cycle pulse.
- SwitchAck, input, 1: OS has saved context and is ready to load NextPID.
- SwitchReq, output, 1: context switch requested; held until SwitchAck.
- NextPID, output, 5: PID to run after the switch; valid while SwitchReq=1.
- PIDAtual, output, 5: currently running PID.
- DeslocamentoMemoria, output, 32: PIDAtual << PAGE_LOG2, zero-extended.
- QuantumRestante, output, 16: remaining cycles of the current slice.
- Ocioso, output, 1: no process is ready (state OCIOSO).

Behaviour:
- Reset (Reset=0 at posedge):
  - Ready table cleared; state OCIOSO.
  - SwitchReq=0, NextPID=0, PIDAtual=0, DeslocamentoMemoria=0, QuantumRestante=0, Ocioso=1.
  - Reset mid-operation aborts any pending request with no ack needed.
- Table updates (every state):
  - Criar sets ready[CriarPID]; Matar clears ready[MatarPID].
  - PIDs >= NUM_PROC are ignored.
  - Same PID created and killed in the same cycle: kill wins.
  - Updates take effect at the posedge; the next-PID search uses the registered table.
- Next-PID search (combinational): first ready PID scanning PIDAtual+1, PIDAtual+2, ... wrapping modulo NUM_PROC, ending with PIDAtual itself.
- States:
  - OCIOSO: Ocioso=1. When any ready bit is set, go to PEDIDO with NextPID = search result, latched.
  - EXEC: PIDAtual runs; QuantumRestante decrements by 1 on each Enable=1 cycle. Leave EXEC on any of:
    - QuantumRestante reaches 1 with Enable=1 (expiry),
    - Yield=1,
    - ready[PIDAtual] becomes 0 (killed).
    On leaving EXEC:
    - If the search finds a different ready PID, go to PEDIDO.
    - If only PIDAtual is ready (expiry or yield), reload QUANTUM and stay in EXEC with no request.
    - If nothing is ready, go to OCIOSO.
    - Yield and expiry in the same cycle are treated as a single event.
  - PEDIDO: SwitchReq=1 and NextPID stable.
    - If ready[NextPID] clears while waiting, re-run the search; go to OCIOSO if nothing is ready, otherwise update NextPID.
    - SwitchAck=1 goes to TROCA. SwitchAck outside PEDIDO is ignored.
  - TROCA (1 cycle):
    - PIDAtual <= NextPID; DeslocamentoMemoria <= NextPID << PAGE_LOG2; QuantumRestante <= QUANTUM; SwitchReq <= 0; go to EXEC.
- Latency:
  - Expiry to SwitchReq: 1 cycle.
  - SwitchAck to new PIDAtual/DeslocamentoMemoria: 1 cycle (TROCA), then EXEC on the following cycle.
- Enable=0 freezes the quantum counter only; requests and acks still proceed.

Decomposition:
- Shared package escalonador_pkg holds:
  - State encoding: OCIOSO=2'd0, EXEC=2'd1, PEDIDO=2'd2, TROCA=2'd3.
  - PID_W=5 and the quantum counter width of 16.
- One sub-module, busca_round_robin: purely combinational rotating priority search. It takes the ready vector and the current PID and returns the next PID plus a found flag.

Test Plan:
- Reset, then Criar PID 3 → Ocioso falls; SwitchReq=1 with NextPID=3. SwitchAck → PIDAtual=3, DeslocamentoMemoria=0x00000C00, QuantumRestante=64.
- PIDs 1, 2, 5 ready, running 2, QUANTUM=4 → after 4 Enable cycles SwitchReq=1 with NextPID=5. Next wrap goes 5→1.
- Only PID 4 ready, quantum expires → SwitchReq stays 0 and QuantumRestante reloads to 64.
- Yield while running 1 with 6 also ready → SwitchReq=1, NextPID=6 on the next cycle. Yield and expiry in the same cycle give one request.
- In PEDIDO with NextPID=6, Matar 6 (PID 7 ready) → NextPID changes to 7 before ack. If no PID remains ready → OCIOSO, SwitchReq=0.
- Criar and Matar of PID 2 in the same cycle → ready[2]=0. Criar PID 9 with NUM_PROC=8 → ignored. Reset asserted in PEDIDO → all outputs return to their reset values.
